// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// baud-rate field width and the power-on bit period.
package uart_pkg;

  localparam int BR_W = 15;

  // 100 MHz system clock, 9600 baud
  localparam logic [BR_W-1:0] UART_DEFAULT_BR = 15'd10417;

  // Two-bit encoding; the unused code 2'd3 falls back to IDLE in the FSM.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin winner selection for the UART transmit arbiter.
// The search starts at rr_ptr and wraps upward through the requesters.
// Build option UART_TX_ARB_PRIO0_EN: when defined, requester 0 wins whenever
// it is requesting and the others share the round-robin; when undefined all
// requesters are treated equally.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         rr_ptr,
  output logic [2:0]         winner,
  output logic               any
);

  logic [NUM_REQ-1:0] w_cand;

  // Candidate mask: with priority enabled, a pending requester 0 hides all others.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
`ifdef UART_TX_ARB_PRIO0_EN
      if (gi == 0) begin : g_prio
        assign w_cand[gi] = req[0];
      end else begin : g_rest
        assign w_cand[gi] = req[gi] & ~req[0];
      end
`else
      assign w_cand[gi] = req[gi];
`endif
    end
  endgenerate

  // Walk offsets from far to near so the candidate closest to rr_ptr is kept.
  always_comb begin
    winner = 3'd0;
    any    = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (w_cand[idx]) begin
        winner = 3'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// UART transmit arbiter: picks one of NUM_REQ byte requesters round-robin,
// hands the byte to a UART_Tx core and waits for its stop bit to finish.
// Baud-rate writes are held in a shadow register and only applied while the
// arbiter is idle and the UART is ready, so a byte never changes speed mid-frame.
// Build option UART_TX_ARB_PRIO0_EN (see uart_rr_pick) gives requester 0
// absolute priority.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int              NUM_REQ    = 4,
  parameter logic [BR_W-1:0] DEFAULT_BR = UART_DEFAULT_BR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic                   done,
  output logic [2:0]             grant_id,
  output logic                   busy,
  input  logic                   br_wr,
  input  logic [BR_W-1:0]        br_in,
  output logic [BR_W-1:0]        br_clocks,
  output logic                   br_pending,
  output logic                   tx_enable,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  input  logic                   tx_complete
);

  arb_state_t         r_state,      w_state_next;
  logic               r_tx_enable,  w_tx_enable_next;
  logic [7:0]         r_tx_data,    w_tx_data_next;
  logic [NUM_REQ-1:0] r_req_ack,    w_req_ack_next;
  logic               r_done,       w_done_next;
  logic               r_busy,       w_busy_next;
  logic [2:0]         r_grant_id,   w_grant_id_next;
  logic [2:0]         r_rr_ptr,     w_rr_ptr_next;
  logic               r_br_pending, w_br_pending_next;
  logic [BR_W-1:0]    r_br_clocks,  w_br_clocks_next;
  logic [BR_W-1:0]    r_br_shadow,  w_br_shadow_next;

  logic [2:0]         w_winner;
  logic               w_any;
  logic [7:0]         w_pick_byte;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req),
    .rr_ptr  (r_rr_ptr),
    .winner  (w_winner),
    .any     (w_any)
  );

  assign w_pick_byte = 8'(req_data >> (8 * w_winner));

  // State register and all registered outputs; reset leaves the arbiter idle
  // at the power-on bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_tx_enable  <= 1'b0;
      r_tx_data    <= 8'd0;
      r_req_ack    <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_grant_id   <= 3'd0;
      r_rr_ptr     <= 3'd0;
      r_br_pending <= 1'b0;
      r_br_clocks  <= DEFAULT_BR;
      r_br_shadow  <= DEFAULT_BR;
    end else begin
      r_state      <= w_state_next;
      r_tx_enable  <= w_tx_enable_next;
      r_tx_data    <= w_tx_data_next;
      r_req_ack    <= w_req_ack_next;
      r_done       <= w_done_next;
      r_busy       <= w_busy_next;
      r_grant_id   <= w_grant_id_next;
      r_rr_ptr     <= w_rr_ptr_next;
      r_br_pending <= w_br_pending_next;
      r_br_clocks  <= w_br_clocks_next;
      r_br_shadow  <= w_br_shadow_next;
    end
  end

  // Next-state logic: baud apply takes precedence over a grant, and a baud
  // write in any cycle (including the apply cycle) re-arms the pending flag.
  always_comb begin
    w_state_next      = r_state;
    w_tx_enable_next  = r_tx_enable;
    w_tx_data_next    = r_tx_data;
    w_req_ack_next    = '0;
    w_done_next       = 1'b0;
    w_busy_next       = r_busy;
    w_grant_id_next   = r_grant_id;
    w_rr_ptr_next     = r_rr_ptr;
    w_br_pending_next = r_br_pending;
    w_br_clocks_next  = r_br_clocks;
    w_br_shadow_next  = r_br_shadow;

    case (r_state)
      ST_IDLE: begin
        w_tx_enable_next = 1'b0;
        w_busy_next      = 1'b0;
        if (r_br_pending && tx_ready) begin
          w_br_clocks_next  = r_br_shadow;
          w_br_pending_next = 1'b0;
        end else if (!r_br_pending && tx_ready && w_any) begin
          w_tx_data_next           = w_pick_byte;
          w_grant_id_next          = w_winner;
          w_req_ack_next[w_winner] = 1'b1;
          w_busy_next              = 1'b1;
          w_tx_enable_next         = 1'b1;
          w_state_next             = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Hold Enable until the UART shows it has taken the byte.
        if (!tx_ready) begin
          w_tx_enable_next = 1'b0;
          w_state_next     = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (tx_complete) begin
          w_done_next   = 1'b1;
          w_busy_next   = 1'b0;
          w_state_next  = ST_IDLE;
          w_rr_ptr_next = (r_grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant_id + 3'd1;
        end
      end

      default: begin
        w_state_next     = ST_IDLE;
        w_tx_enable_next = 1'b0;
        w_busy_next      = 1'b0;
      end
    endcase

    if (br_wr) begin
      w_br_shadow_next  = br_in;
      w_br_pending_next = 1'b1;
    end
  end

  assign req_ack    = r_req_ack;
  assign done       = r_done;
  assign grant_id   = r_grant_id;
  assign busy       = r_busy;
  assign br_clocks  = r_br_clocks;
  assign br_pending = r_br_pending;
  assign tx_enable  = r_tx_enable;
  assign tx_data    = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb with a behavioural UART_Tx model and a
// transaction-level arbitration model checked on every cycle.
module tb_uart_tx_arb;

  localparam int          N      = 4;
  localparam logic [14:0] DEF_BR = 15'd16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ack;
  logic           done;
  logic [2:0]     grant_id;
  logic           busy;
  logic           br_wr = 1'b0;
  logic [14:0]    br_in = 15'd0;
  logic [14:0]    br_clocks;
  logic           br_pending;
  logic           tx_enable;
  logic [7:0]     tx_data;
  logic           tx_ready = 1'b1;
  logic           tx_complete = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .NUM_REQ    (N),
    .DEFAULT_BR (DEF_BR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .done        (done),
    .grant_id    (grant_id),
    .busy        (busy),
    .br_wr       (br_wr),
    .br_in       (br_in),
    .br_clocks   (br_clocks),
    .br_pending  (br_pending),
    .tx_enable   (tx_enable),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_complete (tx_complete)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference arbitration rule: first pending requester at or after ptr, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef UART_TX_ARB_PRIO0_EN
    if (r[0]) return 0;
    r[0] = 1'b0;
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // UART_Tx model: takes a byte on Enable while ready, sends 10 bits at the
  // bit period current at capture, then pulses complete and is ready again.
  // It is never reset, like the real core.
  logic [7:0] cap_q[$];
  int         bp_q[$];
  int         u_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (u_cnt == 0) begin
        tx_complete = 1'b0;
        if (tx_ready && tx_enable) begin
          cap_q.push_back(tx_data);
          bp_q.push_back(int'(br_clocks));
          tx_ready = 1'b0;
          u_cnt = 10 * int'(br_clocks);
        end
      end else begin
        u_cnt--;
        if (u_cnt == 0) begin
          tx_complete = 1'b1;
          tx_ready    = 1'b1;
        end
      end
    end
  end

  // Transaction-level model, checked every cycle on the falling edge.
  int           m_rr = 0;
  bit           m_busy = 1'b0;
  int           m_win = 0;
  logic [7:0]   m_byte = 8'd0;
  logic [14:0]  m_br = DEF_BR;
  logic [14:0]  m_shadow = DEF_BR;
  logic [14:0]  last_brc = DEF_BR;
  int           applies = 0;
  logic [N-1:0] prev_req = '0;
  logic [8*N-1:0] prev_data = '0;
  logic         prev_br_wr = 1'b0;
  int           e;
  logic [7:0]   e_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctrl", {tx_enable, req_ack, done, busy, grant_id, br_pending}, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_br_clocks", br_clocks, DEF_BR);
      m_rr = 0; m_busy = 1'b0; m_shadow = DEF_BR; last_brc = DEF_BR;
    end else begin
      if (done) begin
        chk("done_in_xfer", m_busy, 1);
        chk("done_busy_low", busy, 0);
        m_rr = (m_win + 1) % N;
        m_busy = 1'b0;
      end else if (m_busy) begin
        chk("busy_held", busy, 1);
        chk("data_stable", tx_data, m_byte);
        chk("grant_stable", grant_id, m_win);
        chk("br_frozen", br_clocks, m_br);
      end
      if (req_ack != 0) begin
        e = pick(prev_req, m_rr);
        e_byte = (e < 0) ? 8'd0 : 8'(prev_data >> (8 * e));
        chk("ack_when_free", m_busy, 0);
        chk("ack_vec", req_ack, (e < 0) ? 0 : (1 << e));
        chk("grant_id", grant_id, e);
        chk("grant_data", tx_data, e_byte);
        chk("grant_busy", busy, 1);
        chk("grant_enable", tx_enable, 1);
        chk("grant_br", br_clocks, m_shadow);
        chk("grant_br_pend", br_pending, 0);
        m_busy = 1'b1; m_win = e; m_byte = e_byte; m_br = m_shadow;
      end else if (!m_busy) begin
        chk("idle_quiet", {req_ack, busy, tx_enable}, 0);
      end
      if (prev_br_wr && busy) chk("br_pending_set", br_pending, 1);
      if (br_clocks != last_brc) begin
        chk("br_apply_idle", busy, 0);
        chk("br_apply_val", br_clocks, m_shadow);
        applies++;
      end
      last_brc = br_clocks;
      if (br_wr) m_shadow = br_in;
    end
    prev_req   = req;
    prev_data  = req_data;
    prev_br_wr = br_wr;
  end

  // Run until n done pulses, releasing each requester once acknowledged;
  // optionally issue up to two baud writes at given cycle offsets.
  task automatic serve(input int n, input int wc1, input logic [14:0] v1,
                       input int wc2, input logic [14:0] v2);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 4000 * n) begin
      @(posedge clk);
      #2;
      if (cyc == wc1) begin br_wr = 1'b1; br_in = v1; end
      else if (cyc == wc2) begin br_wr = 1'b1; br_in = v2; end
      else br_wr = 1'b0;
      cyc++;
      if (req_ack != 0) req = req & ~req_ack;
      if (done) got++;
    end
    br_wr = 1'b0;
    chk("serve_done_count", got, n);
  endtask

  task automatic wait_ack();
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 4000) begin
      @(posedge clk);
      #2;
      cyc++;
      if (req_ack != 0) begin req = req & ~req_ack; seen = 1'b1; end
    end
    chk("ack_seen", seen, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int got;
    bit ready_prev;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Four simultaneous requesters go out in index order.
    cap_q.delete(); bp_q.delete();
    req_data = {8'h44, 8'h43, 8'h42, 8'h41};
    req = 4'b1111;
    serve(4, -1, 0, -1, 0);
    chk("s1_count", cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk("s1_b0", cap_q[0], 8'h41);
      chk("s1_b1", cap_q[1], 8'h42);
      chk("s1_b2", cap_q[2], 8'h43);
      chk("s1_b3", cap_q[3], 8'h44);
      chk("s1_bp", bp_q[3], 16);
    end

    // After a grant to 2, requesters 0 and 2 wrap to 0 first.
    cap_q.delete(); bp_q.delete();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b0100;
    serve(1, -1, 0, -1, 0);
    req = 4'b0101;
    serve(2, -1, 0, -1, 0);
    chk("s2_count", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      chk("s2_b0", cap_q[0], 8'h12);
      chk("s2_b1", cap_q[1], 8'h10);
      chk("s2_b2", cap_q[2], 8'h12);
    end

    // Baud write during a byte takes effect only for the next byte.
    cap_q.delete(); bp_q.delete();
    req_data = {8'h00, 8'h00, 8'h66, 8'h55};
    req = 4'b0011;
    serve(2, 20, 15'd100, -1, 0);
    chk("s3_count", cap_q.size(), 2);
    if (cap_q.size() == 2) begin
      chk("s3_b0", cap_q[0], 8'h55);
      chk("s3_bp0", bp_q[0], 16);
      chk("s3_b1", cap_q[1], 8'h66);
      chk("s3_bp1", bp_q[1], 100);
    end
    chk("s3_br", br_clocks, 100);

    // Two writes while busy: last wins, applied once.
    cap_q.delete(); bp_q.delete();
    a0 = applies;
    req_data = {8'h00, 8'h00, 8'h00, 8'h77};
    req = 4'b0001;
    serve(1, 20, 15'd50, 40, 15'd60);
    repeat (5) @(posedge clk);
    #2;
    chk("s4_br", br_clocks, 60);
    chk("s4_pending", br_pending, 0);
    chk("s4_applies", applies - a0, 1);
    if (bp_q.size() == 1) chk("s4_bp", bp_q[0], 100);

    // Reset in WAIT_DONE; no grant until the still-busy UART reports ready.
    cap_q.delete(); bp_q.delete();
    req_data = {8'h00, 8'h00, 8'h88, 8'h00};
    req = 4'b0010;
    got = 0;
    for (int c = 0; c < 4000 && got == 0; c++) begin
      @(posedge clk);
      #2;
      if (busy && !tx_enable && cap_q.size() != 0) got = 1;
    end
    chk("s5_reached_wait", got, 1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #2 ready_prev = tx_ready;
    got = 0;
    for (int c = 0; c < 4000 && got == 0; c++) begin
      @(posedge clk);
      #4;
      if (req_ack != 0) begin
        chk("s5_grant_after_ready", ready_prev, 1);
        req = 4'b0000;
        got = 1;
      end
      ready_prev = tx_ready;
    end
    chk("s5_post_reset_grant", got, 1);
    serve(1, -1, 0, -1, 0);
    chk("s5_count", cap_q.size(), 2);
    if (cap_q.size() == 2) begin
      chk("s5_b0", cap_q[0], 8'h88);
      chk("s5_bp0", bp_q[0], 60);
      chk("s5_b1", cap_q[1], 8'h88);
      chk("s5_bp1", bp_q[1], 16);
    end

    // Requester 0 raises its request in the middle of another byte.
    cap_q.delete(); bp_q.delete();
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'b1110;
    wait_ack();
    req[0] = 1'b1;
    serve(3, -1, 0, -1, 0);
    chk("s6_count", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      chk("s6_b0", cap_q[0], 8'hA2);
`ifdef UART_TX_ARB_PRIO0_EN
      chk("s6_b1", cap_q[1], 8'hA0);
      chk("s6_b2", cap_q[2], 8'hA1);
`else
      chk("s6_b1", cap_q[1], 8'hA3);
      chk("s6_b2", cap_q[2], 8'hA0);
`endif
    end
    req = 4'b0000;
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
